i2s_rx_multi: RTL



---
 rtl/i2s_pkg.sv | 13 +
 rtl/i2s_word_packer.sv | 83 ++++++++
 rtl/i2s_rx_multi.sv | 121 ++++++++++++
 3 files changed

// File: rtl/i2s_pkg.sv
// Shared types and mode encodings for the multi-format serial-audio receiver.
package i2s_pkg;

  typedef enum logic [1:0] {IDLE, SKIP, SHIFT} i2s_state_t;
  typedef enum logic {CH_L, CH_R} i2s_ch_t;

  localparam int DELAY_MSBJ    = 0;
  localparam int DELAY_PHILIPS = 1;

  localparam int ALIGN_RIGHT = 0;
  localparam int ALIGN_LEFT  = 1;

endpackage

// File: rtl/i2s_word_packer.sv
// Word assembly: shift register, saturating bit counter, alignment and
// truncation, with a registered output word.
module i2s_word_packer
  import i2s_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 7,
  parameter int LEFT_J = ALIGN_RIGHT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              shift,
  input  logic              emit,
  input  logic              sd,
  input  i2s_ch_t           ch,
  output logic              out_valid,
  output logic              out_ch,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  out_bits,
  output logic              out_trunc
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [DATA_W-1:0] sreg_p1;
  logic [CNT_W-1:0]  cnt_p1;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (c == CNT_MAX) ? c : c + CNT_W'(1);
  endfunction

  // Bits accumulate right-aligned; left alignment is applied only on emission.
  function automatic logic [DATA_W-1:0] align(input logic [DATA_W-1:0] s,
                                               input logic [CNT_W-1:0]  c);
    if (LEFT_J == ALIGN_LEFT && int'(c) < DATA_W)
      return s << (DATA_W - int'(c));
    return s;
  endfunction

  function automatic logic is_trunc(input logic [CNT_W-1:0] c);
    return int'(c) > DATA_W;
  endfunction

  // Stage p1: word accumulation
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sreg_p1 <= '0;
      cnt_p1  <= '0;
    end else if (start) begin
      sreg_p1 <= {{(DATA_W-1){1'b0}}, sd};
      cnt_p1  <= CNT_W'(1);
    end else if (shift) begin
      if (int'(cnt_p1) < DATA_W)
        sreg_p1 <= {sreg_p1[DATA_W-2:0], sd};
      cnt_p1 <= sat_inc(cnt_p1);
    end
  end

  // Stage p2: registered output word, all-zero when not emitting
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_ch    <= 1'b0;
      out_data  <= '0;
      out_bits  <= '0;
      out_trunc <= 1'b0;
    end else if (emit) begin
      out_valid <= 1'b1;
      out_ch    <= ch;
      out_data  <= align(sreg_p1, cnt_p1);
      out_bits  <= cnt_p1;
      out_trunc <= is_trunc(cnt_p1);
    end else begin
      out_valid <= 1'b0;
      out_ch    <= 1'b0;
      out_data  <= '0;
      out_bits  <= '0;
      out_trunc <= 1'b0;
    end
  end

endmodule

// File: rtl/i2s_rx_multi.sv
// Serial-audio word receiver: splits the SD/WS stream into channel words at
// every tag change and hands each completed word to the packer for output.
module i2s_rx_multi
  import i2s_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 7,
  parameter int DELAY  = DELAY_MSBJ,
  parameter int LEFT_J = ALIGN_RIGHT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic              SD,
  input  logic              WS,
  output logic              out_valid,
  output logic              out_ch,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  out_bits,
  output logic              out_trunc
);

  logic       vld_p0;
  logic       sd_p0;
  logic       ws_p0;
  i2s_state_t state, state_nxt;
  i2s_ch_t    cur_tag, tag_nxt, tag, prev_ws;
  logic       start, shift, emit;

  // Stage p0: pad sampling
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p0 <= 1'b0;
      sd_p0  <= 1'b0;
      ws_p0  <= 1'b0;
    end else begin
      vld_p0 <= in_valid;
      sd_p0  <= SD;
      ws_p0  <= WS;
    end
  end

  // Philips mode tags each bit with the WS seen on the previous valid bit.
  assign tag = (DELAY == DELAY_PHILIPS) ? prev_ws : i2s_ch_t'(ws_p0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cur_tag <= CH_L;
      prev_ws <= CH_L;
    end else begin
      state   <= state_nxt;
      cur_tag <= tag_nxt;
      if (vld_p0)
        prev_ws <= i2s_ch_t'(ws_p0);
    end
  end

  always_comb begin
    state_nxt = state;
    tag_nxt   = cur_tag;
    start     = 1'b0;
    shift     = 1'b0;
    emit      = 1'b0;
    case (state)
      IDLE: begin
        if (vld_p0) begin
          if (DELAY == DELAY_PHILIPS) begin
            state_nxt = SKIP;
          end else begin
            start     = 1'b1;
            tag_nxt   = tag;
            state_nxt = SHIFT;
          end
        end
      end
      SKIP: begin
        if (vld_p0) begin
          start     = 1'b1;
          tag_nxt   = tag;
          state_nxt = SHIFT;
        end else begin
          state_nxt = IDLE;
        end
      end
      SHIFT: begin
        if (!vld_p0) begin
          emit      = 1'b1;
          state_nxt = IDLE;
        end else if (tag != cur_tag) begin
          emit    = 1'b1;
          start   = 1'b1;
          tag_nxt = tag;
        end else begin
          shift = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  i2s_word_packer #(
    .DATA_W(DATA_W),
    .CNT_W (CNT_W),
    .LEFT_J(LEFT_J)
  ) u_packer (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .shift    (shift),
    .emit     (emit),
    .sd       (sd_p0),
    .ch       (cur_tag),
    .out_valid(out_valid),
    .out_ch   (out_ch),
    .out_data (out_data),
    .out_bits (out_bits),
    .out_trunc(out_trunc)
  );

endmodule
